// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// ALU funct codes, FSM state encoding and result constants.
package mul_div_unit_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // divide-by-zero quotient is all ones; replicate to operand width
  localparam logic DIV0_Q_BIT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  function automatic logic is_md(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) ||
           (f == F_DIV)  || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage bundle between the pipeline and the mul/div unit.
// master = pipeline side, slave = mul/div unit.
interface mul_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  flush;
  logic                  stall_req;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [DATA_WIDTH-1:0] mf_data;
  logic                  busy;

  modport master (
    output en, funct, rs_data, rt_data, flush,
    input  stall_req, hi, lo, mf_data, busy
  );

  modport slave (
    input  en, funct, rs_data, rt_data, flush,
    output stall_req, hi, lo, mf_data, busy
  );
endinterface

// File: rtl/mul_div_unit_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle; done flags the final step.
module div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);
  localparam int CW = $clog2(W);

  logic          run;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q;
  logic [W-1:0]  r;
  logic [W-1:0]  d;
  logic [W:0]    rr;
  logic [W:0]    diff;

  // quot/rem are the post-step values, valid when done
  always_comb begin
    rr   = {r, q[W-1]};
    diff = rr - {1'b0, d};
    quot = {q[W-2:0], ~diff[W]};
    rem  = diff[W] ? rr[W-1:0] : diff[W-1:0];
    done = run && (cnt == CW'(W-1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run <= 1'b0;
      cnt <= '0;
      q   <= '0;
      r   <= '0;
      d   <= '0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      q   <= dividend;
      r   <= '0;
      d   <= divisor;
    end else if (run) begin
      q   <= quot;
      r   <= rem;
      cnt <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit; owns HI/LO and stalls the
// pipeline while a multi-cycle MULT/DIV is in flight.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  mul_div_unit_if.slave  bus
);
  localparam int W = DATA_WIDTH;

  md_state_e state, nxt;
  logic [2:0]   cnt;
  logic [W-1:0] a, b, hi_q, lo_q;
  logic         sgn, div0;
  logic         start, is_mul, is_sdiv, mul_last;
  logic [W-1:0] mag_a, mag_b, q_u, r_u;
  logic         dv_done;
  logic [2*W-1:0] ext_a, ext_b, prod;
  logic         neg_q, neg_r;

  always_comb begin
    start = rst && bus.en && !bus.flush &&
            (state == S_IDLE) && is_md(bus.funct);
    is_mul  = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
    is_sdiv = (bus.funct == F_DIV);
    mag_a = (is_sdiv && bus.rs_data[W-1]) ?
            ('0 - bus.rs_data) : bus.rs_data;
    mag_b = (is_sdiv && bus.rt_data[W-1]) ?
            ('0 - bus.rt_data) : bus.rt_data;
    ext_a = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    ext_b = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    prod  = ext_a * ext_b;
    neg_q = sgn && (a[W-1] ^ b[W-1]);
    neg_r = sgn && a[W-1];
    mul_last = (cnt == 3'(MUL_CYCLES - 1));
  end

  div_core #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start && !is_mul && (bus.rt_data != '0)),
    .abort    (bus.flush),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (dv_done),
    .quot     (q_u),
    .rem      (r_u)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start) nxt = is_mul ? S_MUL : S_DIV;
      S_MUL:  if (mul_last) nxt = S_DONE;
      S_DIV:  if (div0 || dv_done) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
    endcase
    // flush aborts anything in flight
    if (bus.flush && state != S_IDLE) nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a <= '0; b <= '0; sgn <= 1'b0; div0 <= 1'b0;
      cnt <= '0;
    end else begin
      if (start) begin
        a    <= bus.rs_data;
        b    <= bus.rt_data;
        sgn  <= (bus.funct == F_MULT) || is_sdiv;
        div0 <= (bus.rt_data == '0);
        cnt  <= '0;
      end else if (state == S_MUL) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!bus.flush) begin
      unique case (1'b1)
        state == S_IDLE && bus.en && bus.funct == F_MTHI:
          hi_q <= bus.rs_data;
        state == S_IDLE && bus.en && bus.funct == F_MTLO:
          lo_q <= bus.rs_data;
        state == S_MUL && mul_last:
          {hi_q, lo_q} <= prod;
        state == S_DIV && div0: begin
          hi_q <= a;
          lo_q <= {W{DIV0_Q_BIT}};
        end
        state == S_DIV && dv_done: begin
          lo_q <= neg_q ? ('0 - q_u) : q_u;
          hi_q <= neg_r ? ('0 - r_u) : r_u;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_req = rst && (start || (!bus.flush &&
                         (state == S_MUL || state == S_DIV)));
  assign bus.busy    = (state != S_IDLE);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mf_data = (bus.funct == F_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an
// arithmetic reference model of HI/LO and stall counts.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_unit_if #(.DATA_WIDTH(32)) bus ();

  mul_div_unit #(.DATA_WIDTH(32), .MUL_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: MIPS semantics in plain integer arithmetic
  task automatic model(input logic [5:0] f,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       output int stalls);
    longint sp;
    logic [63:0] up;
    int sx, sy;
    sx = x; sy = y;
    stalls = 2;
    case (f)
      F_MULT: begin
        sp = longint'(sx) * longint'(sy);
        {m_hi, m_lo} = sp;
      end
      F_MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = up;
      end
      default: begin
        if (y == 0) begin
          m_lo = 32'hFFFFFFFF; m_hi = x;
        end else begin
          stalls = 33;
          if (f == F_DIVU) begin
            m_lo = x / y; m_hi = x % y;
          end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            m_lo = 32'h80000000; m_hi = 0;
          end else begin
            m_lo = sx / sy; m_hi = sx % sy;
          end
        end
      end
    endcase
  endtask

  task automatic do_op(input string tag, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y);
    int n, exp_st;
    model(f, x, y, exp_st);
    @(negedge clk);
    bus.en = 1'b1; bus.funct = f;
    bus.rs_data = x; bus.rt_data = y;
    n = 0;
    #1;
    while (bus.stall_req && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    chk({tag, ".stalls"}, 64'(n), 64'(exp_st));
    chk({tag, ".done_busy"}, 64'(bus.busy), 64'd1);
    chk({tag, ".hi"}, 64'(bus.hi), 64'(m_hi));
    chk({tag, ".lo"}, 64'(bus.lo), 64'(m_lo));
    @(negedge clk);
    bus.en = 1'b0;
    #1;
    chk({tag, ".idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [5:0]  fs [4];
    logic [31:0] x, y;
    fs[0] = F_MULT; fs[1] = F_MULTU; fs[2] = F_DIV; fs[3] = F_DIVU;
    bus.en = 0; bus.funct = 0; bus.flush = 0;
    bus.rs_data = 0; bus.rt_data = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.stall", 64'(bus.stall_req), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.hi", 64'(bus.hi), 64'd0);
    chk("rst.lo", 64'(bus.lo), 64'd0);
    rst = 1'b1;

    do_op("mult", F_MULT, 32'hFFFFFFFD, 32'd7);
    do_op("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("div", F_DIV, 32'hFFFFFFF9, 32'd2);
    do_op("divu", F_DIVU, 32'd100, 32'd7);
    do_op("divu0", F_DIVU, 32'd5, 32'd0);
    do_op("divovf", F_DIV, 32'h80000000, 32'hFFFFFFFF);

    // MTHI then MF reads
    @(negedge clk);
    bus.en = 1; bus.funct = F_MTHI; bus.rs_data = 32'hDEADBEEF;
    m_hi = 32'hDEADBEEF;
    @(negedge clk);
    bus.en = 0; bus.funct = F_MFLO; #1;
    chk("mflo", 64'(bus.mf_data), 64'(m_lo));
    bus.funct = F_MFHI; #1;
    chk("mfhi", 64'(bus.mf_data), 64'(32'hDEADBEEF));
    @(negedge clk);
    bus.en = 1; bus.funct = F_MTLO; bus.rs_data = 32'h1234; bus.flush = 1;
    @(negedge clk);
    bus.en = 0; bus.flush = 0; #1;
    chk("mtlo_flush", 64'(bus.lo), 64'(m_lo));
    @(negedge clk);
    bus.en = 1; bus.funct = F_MTLO; bus.rs_data = 32'h5678;
    m_lo = 32'h5678;
    @(negedge clk);
    bus.en = 0; #1;
    chk("mtlo", 64'(bus.lo), 64'(m_lo));

    // flush in the middle of a divide
    @(negedge clk);
    bus.en = 1; bus.funct = F_DIVU; bus.rs_data = 1000; bus.rt_data = 3;
    repeat (11) @(negedge clk);
    bus.flush = 1; #1;
    chk("flush.stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    bus.flush = 0; bus.en = 0; #1;
    chk("flush.busy", 64'(bus.busy), 64'd0);
    chk("flush.hi", 64'(bus.hi), 64'(m_hi));
    chk("flush.lo", 64'(bus.lo), 64'(m_lo));

    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) y = 0;
      do_op($sformatf("rnd%0d", i), fs[$urandom_range(0, 3)], x, y);
    end

    // reset in the middle of a multiply
    @(negedge clk);
    bus.en = 1; bus.funct = F_MULT; bus.rs_data = 5; bus.rt_data = 6;
    @(negedge clk);
    rst = 0; bus.en = 0; #1;
    chk("rstmul.stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk); #1;
    m_hi = 0; m_lo = 0;
    chk("rstmul.hi", 64'(bus.hi), 64'(m_hi));
    chk("rstmul.lo", 64'(bus.lo), 64'(m_lo));
    chk("rstmul.busy", 64'(bus.busy), 64'd0);
    rst = 1;
    do_op("post_rst", F_MULTU, 32'd12345, 32'd678);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
